// File: rtl/tc_pkg.sv
// Shared widths, FSM state codes and saturation bounds for the product
// accumulator stage.
package tc_pkg;

  localparam int PW_DEF = 16;
  localparam int AW_DEF = 18;

  typedef logic [0:0] state_t;
  localparam state_t ST_ACC  = 1'b0;
  localparam state_t ST_HOLD = 1'b1;

  localparam logic signed [AW_DEF-1:0] SAT_MAX = {1'b0, {(AW_DEF-1){1'b1}}};
  localparam logic signed [AW_DEF-1:0] SAT_MIN = {1'b1, {(AW_DEF-1){1'b0}}};

endpackage

// File: rtl/tc_sat_add.sv
// Combinational signed AW + PW -> AW adder that clamps to the AW-bit range
// and flags when clamping happened.
module tc_sat_add #(
  parameter int AW = 18,
  parameter int PW = 16
) (
  input  logic [AW-1:0] a,
  input  logic [PW-1:0] b,
  output logic [AW-1:0] y,
  output logic          sat
);

  localparam logic [AW-1:0] MAXV = {1'b0, {(AW-1){1'b1}}};
  localparam logic [AW-1:0] MINV = {1'b1, {(AW-1){1'b0}}};

  logic [AW:0] s;

  // One guard bit: the two top bits disagree exactly when the AW-bit result overflowed.
  always_comb begin
    s   = {a[AW-1], a} + {{(AW+1-PW){b[PW-1]}}, b};
    sat = s[AW] ^ s[AW-1];
    y   = sat ? (s[AW] ? MINV : MAXV) : s[AW-1:0];
  end

endmodule

// File: rtl/tc_prod_acc.sv
// Accumulates N_LEN signed products per block with per-step saturation and
// presents each block sum on a valid/ready output with a sticky overflow flag.
module tc_prod_acc
  import tc_pkg::*;
#(
  parameter int PW    = PW_DEF,
  parameter int AW    = AW_DEF,
  parameter int N_LEN = 8,
  parameter int CW    = $clog2(N_LEN)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [PW-1:0] p,
  input  logic          p_valid,
  output logic          p_ready,
  input  logic          clear,
  output logic [AW-1:0] sum,
  output logic          sum_valid,
  input  logic          sum_ready,
  output logic          ovf,
  output logic [CW-1:0] term_cnt
);

  localparam logic [CW-1:0] LAST_TERM = CW'(N_LEN - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_acc_q, ovf_acc_d;
  logic [AW-1:0] sum_q, sum_d;
  logic          ovf_q, ovf_d;
  logic          sum_valid_q, sum_valid_d;

  logic [AW-1:0] add_y;
  logic          add_sat;
  logic          accept;

  tc_sat_add #(.AW(AW), .PW(PW)) u_sat_add (
    .a   (acc_q),
    .b   (p),
    .y   (add_y),
    .sat (add_sat)
  );

  assign p_ready   = (state_q == ST_ACC) && rst_n;
  assign accept    = p_valid && p_ready;
  assign sum       = sum_q;
  assign ovf       = ovf_q;
  assign sum_valid = sum_valid_q;
  assign term_cnt  = cnt_q;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_acc_d   = ovf_acc_q;
    sum_d       = sum_q;
    ovf_d       = ovf_q;
    sum_valid_d = sum_valid_q;

    // clear wins over both an accept and a sum handshake; sum/ovf data survive it
    if (clear) begin
      acc_d       = '0;
      cnt_d       = '0;
      ovf_acc_d   = 1'b0;
      sum_valid_d = 1'b0;
      state_d     = ST_ACC;
    end else if (accept) begin
      if (cnt_q == LAST_TERM) begin
        sum_d       = add_y;
        ovf_d       = ovf_acc_q | add_sat;
        sum_valid_d = 1'b1;
        state_d     = ST_HOLD;
        acc_d       = '0;
        cnt_d       = '0;
        ovf_acc_d   = 1'b0;
      end else begin
        acc_d     = add_y;
        cnt_d     = cnt_q + CW'(1);
        ovf_acc_d = ovf_acc_q | add_sat;
      end
    end else if (state_q == ST_HOLD && sum_valid_q && sum_ready) begin
      sum_valid_d = 1'b0;
      state_d     = ST_ACC;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_acc_q   <= 1'b0;
      sum_q       <= '0;
      ovf_q       <= 1'b0;
      sum_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_acc_q   <= ovf_acc_d;
      sum_q       <= sum_d;
      ovf_q       <= ovf_d;
      sum_valid_q <= sum_valid_d;
    end
  end

endmodule
